// File: rtl/arb_pkg.sv
// Shared constants, state encoding and BCD helper for the 10-way round-robin arbiter.
package arb_pkg;

    localparam int         N_REQ    = 10;
    localparam logic [3:0] NO_GRANT = 4'hF;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_GAP   = 2'd2
    } state_t;

    // Sum of two BCD digits, modulo 10; both operands are expected in 0..9.
    function automatic logic [3:0] mod10_add(input logic [3:0] a, input logic [3:0] b);
        logic [4:0] s;
        s = {1'b0, a} + {1'b0, b};
        if (s >= 5'd10) s = s - 5'd10;
        return s[3:0];
    endfunction

endpackage

// File: rtl/rr_pick10.sv
// Rotating-priority picker: first set request at or after ptr, wrapping 9 -> 0.
module rr_pick10
    import arb_pkg::*;
(
    input  logic [N_REQ-1:0] req,
    input  logic [3:0]       ptr,
    output logic             found,
    output logic [3:0]       idx,
    output logic [N_REQ-1:0] onehot
);

    logic [N_REQ-1:0] rot;
    logic [3:0]       off;

    always_comb begin
        rot = '0;
        for (int i = 0; i < N_REQ; i++) begin
            rot[i] = req[mod10_add(4'(i), ptr)];
        end
    end

    // NOTE: every output of an always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        found = 1'b0;
        off   = 4'd0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (rot[i]) begin
                found = 1'b1;
                off   = 4'(i);
            end
        end
        idx    = found ? mod10_add(off, ptr) : NO_GRANT;
        onehot = found ? ({{(N_REQ-1){1'b0}}, 1'b1} << idx) : '0;
    end

endmodule

// File: rtl/rr_arbiter_bcd10.sv
// Round-robin arbiter for 10 requesters: registered one-hot grant, BCD index,
// hold-until-done with forced release after TIMEOUT cycles, and one GAP cycle per release.
module rr_arbiter_bcd10
    import arb_pkg::*;
#(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_REQ-1:0] req,
    input  logic             done,
    output logic [N_REQ-1:0] gnt,
    output logic [3:0]       gnt_idx,
    output logic             gnt_valid,
    output logic             timeout
);

    state_t             state_q, state_d;
    logic [3:0]         ptr_q, ptr_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [N_REQ-1:0]   gnt_q, gnt_d;
    logic [3:0]         idx_q, idx_d;
    logic               valid_q, valid_d;
    logic               timeout_q, timeout_d;

    logic               pick_found;
    logic [3:0]         pick_idx;
    logic [N_REQ-1:0]   pick_onehot;

    logic               rel_drop;
    logic               rel_cnt;
    logic               release_now;

    rr_pick10 u_pick (
        .req    (req),
        .ptr    (ptr_q),
        .found  (pick_found),
        .idx    (pick_idx),
        .onehot (pick_onehot)
    );

    // Priority done > request drop > timeout only matters for the timeout pulse.
    assign rel_drop    = ~|(req & gnt_q);
    assign rel_cnt     = (cnt_q == CNT_W'(TIMEOUT - 1));
    assign release_now = (state_q == ST_GRANT) && (done || rel_drop || rel_cnt);

    // NOTE: state registers use non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            ptr_q     <= 4'd0;
            cnt_q     <= '0;
            gnt_q     <= '0;
            idx_q     <= NO_GRANT;
            valid_q   <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            cnt_q     <= cnt_d;
            gnt_q     <= gnt_d;
            idx_q     <= idx_d;
            valid_q   <= valid_d;
            timeout_q <= timeout_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:  if (pick_found) state_d = ST_GRANT;
            ST_GRANT: if (release_now) state_d = ST_GAP;
            ST_GAP:   state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        ptr_d     = ptr_q;
        cnt_d     = cnt_q;
        gnt_d     = gnt_q;
        idx_d     = idx_q;
        valid_d   = valid_q;
        timeout_d = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (pick_found) begin
                    gnt_d   = pick_onehot;
                    idx_d   = pick_idx;
                    valid_d = 1'b1;
                    cnt_d   = '0;
                end
            end
            ST_GRANT: begin
                if (release_now) begin
                    gnt_d     = '0;
                    idx_d     = NO_GRANT;
                    valid_d   = 1'b0;
                    ptr_d     = mod10_add(idx_q, 4'd1);
                    timeout_d = rel_cnt && !done && !rel_drop;
                end else if (cnt_q != {CNT_W{1'b1}}) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                gnt_d   = '0;
                idx_d   = NO_GRANT;
                valid_d = 1'b0;
            end
        endcase
    end

    assign gnt       = gnt_q;
    assign gnt_idx   = idx_q;
    assign gnt_valid = valid_q;
    assign timeout   = timeout_q;

endmodule

// File: tb/tb_rr_arbiter_bcd10.sv
// Scoreboard bench: stimulus pushes expected grants (index, hold length, timeout flag);
// a negedge monitor pops one per observed grant and checks it through its release.
module tb_rr_arbiter_bcd10;

    typedef struct {
        logic [3:0] idx;
        int         len;
        logic       to;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic [9:0] req;
    logic       done;
    logic [9:0] gnt;
    logic [3:0] gnt_idx;
    logic       gnt_valid;
    logic       timeout;

    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];

    rr_arbiter_bcd10 #(.TIMEOUT(16), .CNT_W(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .done      (done),
        .gnt       (gnt),
        .gnt_idx   (gnt_idx),
        .gnt_valid (gnt_valid),
        .timeout   (timeout)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [3:0] idx, input int len, input logic to);
        exp_t e;
        e.idx = idx;
        e.len = len;
        e.to  = to;
        sb.push_back(e);
    endtask

    task automatic wait_grant();
        int n = 0;
        while (!gnt_valid && n < 50) begin
            tick();
            n++;
        end
        check("grant_seen", 32'(gnt_valid), 32'd1);
    endtask

    task automatic wait_release();
        int n = 0;
        while (gnt_valid && n < 40) begin
            tick();
            n++;
        end
        check("release_seen", 32'(gnt_valid), 32'd0);
    endtask

    task automatic done_pulse();
        done = 1'b1;
        tick();
        done = 1'b0;
    endtask

    task automatic check_idle_outputs(input string name);
        check({name, "_gnt"},     32'(gnt),       32'd0);
        check({name, "_idx"},     32'(gnt_idx),   32'hF);
        check({name, "_valid"},   32'(gnt_valid), 32'd0);
        check({name, "_timeout"}, 32'(timeout),   32'd0);
    endtask

    // Monitor: one scoreboard entry per grant, closed out when gnt_valid falls.
    initial begin
        logic prev_valid = 1'b0;
        logic active     = 1'b0;
        int   len        = 0;
        exp_t cur;
        cur.idx = 4'hF;
        cur.len = 0;
        cur.to  = 1'b0;
        forever begin
            @(negedge clk);
            if (gnt_valid === 1'b1 && !prev_valid) begin
                if (sb.size() == 0) begin
                    check("unexpected_grant_idx", 32'(gnt_idx), 32'hF);
                    active = 1'b0;
                end else begin
                    cur = sb.pop_front();
                    check("grant_idx", 32'(gnt_idx), 32'(cur.idx));
                    check("grant_onehot", 32'(gnt), 32'(10'b1 << cur.idx));
                    active = 1'b1;
                    len    = 1;
                end
            end else if (gnt_valid === 1'b1 && active) begin
                len++;
                if (gnt_idx !== cur.idx) check("grant_frozen", 32'(gnt_idx), 32'(cur.idx));
            end else if (gnt_valid !== 1'b1 && prev_valid) begin
                if (active) begin
                    check("hold_len", 32'(len), 32'(cur.len));
                    check("timeout_pulse", 32'(timeout), 32'(cur.to));
                    check("release_idx", 32'(gnt_idx), 32'hF);
                end
                active = 1'b0;
            end else if (timeout !== 1'b0) begin
                check("stray_timeout", 32'(timeout), 32'd0);
            end
            prev_valid = (gnt_valid === 1'b1);
        end
    end

    initial begin
        rst  = 1'b1;
        req  = '0;
        done = 1'b0;
        tick();
        tick();
        check_idle_outputs("reset");
        rst = 1'b0;

        // Move ptr to 3, then hold a grant to 2 and reset in the middle of it.
        push(4'd2, 1, 1'b0);
        req = 10'b0000000100;
        wait_grant();
        done_pulse();
        push(4'd2, 1, 1'b0);
        wait_grant();
        rst = 1'b1;
        tick();
        check_idle_outputs("rst_mid_grant");
        rst = 1'b0;
        // ptr=0 after reset picks 2; a stale ptr of 3 would pick 3.
        req = 10'b0000001100;
        push(4'd2, 1, 1'b0);
        wait_grant();
        done_pulse();
        req = '0;
        rst = 1'b1;
        tick();
        rst = 1'b0;

        // Round-robin order from ptr=0.
        push(4'd0, 1, 1'b0);
        push(4'd5, 1, 1'b0);
        push(4'd9, 1, 1'b0);
        push(4'd0, 1, 1'b0);
        push(4'd5, 1, 1'b0);
        req = 10'b1000100001;
        repeat (5) begin
            wait_grant();
            done_pulse();
        end
        req = '0;

        // Wrap-around: grant 8 sets ptr=9, then 0 and 1.
        push(4'd8, 1, 1'b0);
        push(4'd0, 1, 1'b0);
        push(4'd1, 1, 1'b0);
        req = 10'b0100000000;
        wait_grant();
        done_pulse();
        req = 10'b0000000011;
        wait_grant();
        done_pulse();
        wait_grant();
        done_pulse();
        req = '0;

        // Timeout on idx 6; then ptr=7 must prefer 7 over 6.
        push(4'd6, 16, 1'b1);
        req = 10'b0001000000;
        wait_grant();
        wait_release();
        req = 10'b0011000000;
        push(4'd7, 1, 1'b0);
        wait_grant();
        done_pulse();
        req = '0;

        // Request drop on idx 3 (ptr=8 wraps).
        push(4'd3, 1, 1'b0);
        req = 10'b0000001000;
        wait_grant();
        req = '0;
        tick();

        // done coincides with the timeout edge: no pulse.
        push(4'd5, 16, 1'b0);
        req = 10'b0000100000;
        wait_grant();
        repeat (15) tick();
        done_pulse();
        req = '0;

        // Idle with done toggling; ptr stays 6.
        repeat (20) begin
            done = ~done;
            tick();
            check("idle_valid", 32'(gnt_valid), 32'd0);
            check("idle_idx", 32'(gnt_idx), 32'hF);
        end
        done = 1'b0;
        push(4'd6, 1, 1'b0);
        req = 10'b1111111111;
        wait_grant();
        done_pulse();
        req = '0;

        repeat (4) tick();
        check("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/rr_arbiter_bcd10.md
Name: rr_arbiter_bcd10

Overview:
- Round-robin arbiter sharing one resource among 10 requesters.
- Outputs a one-hot grant plus a 4-bit BCD grant index, in the same code space as the cd40147 10-to-4 encoder.
- Grants are held until the requester signals done, drops its request, or times out.
- Sits between the request lines (keypad/channel inputs) and the shared downstream datapath.

Parameters:
- TIMEOUT, default 16: maximum cycles a grant is held without done; valid range 2..255.
- CNT_W, default 8: width of the hold counter; must satisfy 2^CNT_W >= TIMEOUT.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- req  input  10  request lines; bit k = requester k.
- done  input  1  current grantee finished; sampled only in GRANT.
- gnt  output  10  one-hot grant, registered.
- gnt_idx  output  4  BCD index 0..9 of grantee; 4'hF when no grant.
- gnt_valid  output  1  high while a grant is held (equals |gnt).
- timeout  output  1  one-cycle pulse on forced release.

Behaviour:
- All outputs are registered.
- Reset, sampled at a clk edge with rst=1:
  - state=IDLE, ptr=0, cnt=0.
  - gnt=0, gnt_idx=4'hF, gnt_valid=0, timeout=0.
  - rst overrides everything, including mid-grant; the grant drops on that edge.
- States: IDLE, GRANT, GAP.
- IDLE:
  - If req!=0, select the first set bit searching ptr, ptr+1, ..., 9, 0, ..., ptr-1.
  - On that edge: gnt, gnt_idx, gnt_valid load; cnt=0; go to GRANT.
  - Latency: request sampled at edge n, gnt_valid=1 after edge n.
  - If req==0, stay in IDLE.
- GRANT:
  - gnt/gnt_idx are frozen; changes on other req bits are ignored.
  - Release conditions, priority order:
    - (a) done=1 -> normal release.
    - (b) req[gnt_idx]=0 -> treated as done.
    - (c) cnt==TIMEOUT-1 -> forced release; timeout=1 for exactly one cycle.
  - If done and the timeout condition coincide, done wins and no timeout pulse is issued.
  - On any release: gnt=0, gnt_idx=4'hF, gnt_valid=0; ptr = gnt_idx+1, with 9 wrapping to 0; go to GAP.
  - Otherwise cnt increments and saturates; no wrap.
- GAP:
  - One mandatory idle cycle; no grant issued; timeout returns to 0.
  - Next state is IDLE. Arbitration therefore resumes one cycle later, giving at most one grant per 3 cycles minimum.
- done is ignored in IDLE and GAP.
- ptr is updated only on release; it is never updated in IDLE.
- gnt_idx is always in 0..9 or 4'hF; no other codes are produced.
- Fairness: a continuously asserting requester is served within 10 grants.

Decomposition:
- Shared package (arb_pkg):
  - localparam NO_GRANT = 4'hF.
  - State encoding localparams ST_IDLE, ST_GRANT, ST_GAP.
  - localparam N_REQ = 10.
- One natural sub-module: rr_pick10, a combinational rotating priority picker.
  - Inputs: req[9:0], ptr[3:0].
  - Outputs: found, idx[3:0] (BCD), onehot[9:0].
  - Implemented as a rotate by ptr, then a lowest-set-bit find, then (result+ptr) mod 10.
- The arbiter FSM, counter and output registers live in rr_arbiter_bcd10.

Test Plan:
- Reset mid-grant:
  - Stimulus: hold req=10'b0000000100 until granted (gnt_idx=2), then assert rst for 1 cycle.
  - Required: next edge gives gnt=0, gnt_idx=4'hF, gnt_valid=0; after rst drops, a re-grant to idx 2 with ptr=0.
- Round-robin order:
  - Stimulus: req=10'b1000100001 held; pulse done one cycle after each grant.
  - Required: grant sequence 0,5,9,0,5, each with gnt one-hot matching, separated by one GAP cycle.
- Wrap-around:
  - Stimulus: set ptr to 9 via a grant to 8; then req=10'b0000000011.
  - Required: grant idx 0, then 1.
- Timeout:
  - Stimulus: TIMEOUT=16, req=10'b0001000000, done never asserted.
  - Required: gnt_idx=6 for exactly 16 cycles; timeout=1 on the release cycle; ptr=7.
- Request drop and collision:
  - Stimulus 1: granted idx 3, then req[3] deasserted without done.
  - Required 1: release on the next edge, no timeout pulse.
  - Stimulus 2: done and timeout in the same cycle.
  - Required 2: timeout stays 0.
- Idle:
  - Stimulus: req=0 for 20 cycles; done toggling.
  - Required: gnt_idx=4'hF, gnt_valid=0 throughout; ptr unchanged.
